// File: rtl/alu_pkg.sv
// Shared types for the sequential RV32 ALU: control codes, ALUOP classes,
// FSM states and a shift-class helper. No ports.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_OR   = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_t;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    function automatic logic is_shift(input alu_ctrl_t c);
        return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control decoder: ALUOP class + funct3 + alt_op.
// Ports: aluop/funct3/alt_op in, alu_ctrl out (alu_ctrl_t).
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [2:0] funct3,
    input  logic       alt_op,
    output alu_ctrl_t  alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                unique case (funct3)
                    3'b000: alu_ctrl = alt_op ? ALU_SUB : ALU_ADD;
                    3'b001: alu_ctrl = ALU_SLL;
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b011: alu_ctrl = ALU_SLTU;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b101: alu_ctrl = alt_op ? ALU_SRA : ALU_SRL;
                    3'b110: alu_ctrl = ALU_OR;
                    3'b111: alu_ctrl = ALU_AND;
                endcase
            end
            // ALUOP_ADD and all undefined classes fall back to ADD
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered ALU with valid/ready handshake; shifts run SHIFT_STEP bits/cycle.
// Ports: clk, rst (async high), in_valid/in_ready, aluop, funct3, alt_op,
// op_a, op_b in; out_valid/out_ready, result, zero, alu_ctrl out.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      aluop,
    input  logic [2:0]      funct3,
    input  logic            alt_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      alu_ctrl
);

    localparam int SHW = $clog2(XLEN);
    // one extra bit so STEP == XLEN is representable
    localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

    state_t          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    alu_ctrl_t       ctrl_q, ctrl_d;
    logic [SHW:0]    rem_q, rem_d;

    alu_ctrl_t       dec_ctrl;
    logic            accept;
    logic [SHW:0]    shamt;
    logic [SHW:0]    step;
    logic [XLEN-1:0] op_res;
    logic [XLEN-1:0] sh_res;

    alu_op_decode u_dec (
        .aluop    (aluop),
        .funct3   (funct3),
        .alt_op   (alt_op),
        .alu_ctrl (dec_ctrl)
    );

    assign shamt    = {1'b0, op_b[SHW-1:0]};
    assign in_ready = (state_q == S_IDLE) ||
                      ((state_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    // last iteration may be shorter than SHIFT_STEP
    assign step     = (rem_q < STEP) ? rem_q : STEP;

    always_comb begin
        op_res = op_a + op_b;
        case (dec_ctrl)
            ALU_SUB:  op_res = op_a - op_b;
            ALU_AND:  op_res = op_a & op_b;
            ALU_OR:   op_res = op_a | op_b;
            ALU_XOR:  op_res = op_a ^ op_b;
            ALU_SLT:  op_res = {{(XLEN-1){1'b0}},
                                $signed(op_a) < $signed(op_b)};
            ALU_SLTU: op_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default:  op_res = op_a + op_b;
        endcase
    end

    always_comb begin
        sh_res = res_q >> step;
        case (ctrl_q)
            ALU_SLL: sh_res = res_q << step;
            ALU_SRA: sh_res = $signed(res_q) >>> step;
            default: sh_res = res_q >> step;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ctrl_d  = ctrl_q;
        rem_d   = rem_q;
        case (state_q)
            S_SHIFT: begin
                res_d = sh_res;
                rem_d = rem_q - step;
                if (rem_q == step) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: ;
        endcase
        // an accept in DONE overrides the drain to IDLE (back-to-back)
        if (accept) begin
            ctrl_d = dec_ctrl;
            if (is_shift(dec_ctrl)) begin
                res_d   = op_a;
                rem_d   = shamt;
                state_d = (shamt == '0) ? S_DONE : S_SHIFT;
            end else begin
                res_d   = op_res;
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            ctrl_q  <= ALU_ADD;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ctrl_q  <= ctrl_d;
            rem_q   <= rem_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign zero      = (res_q == '0);
    assign alu_ctrl  = ctrl_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (SHIFT_STEP=1 main unit, SHIFT_STEP=8
// second unit) against a transaction-level reference model.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  aluop = 3'b0;
    logic [2:0]  funct3 = 3'b0;
    logic        alt_op = 1'b0;
    logic [31:0] op_a = 32'b0;
    logic [31:0] op_b = 32'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic [3:0]  alu_ctrl;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [2:0]  aluop8 = 3'b0;
    logic [2:0]  funct38 = 3'b0;
    logic        alt_op8 = 1'b0;
    logic [31:0] op_a8 = 32'b0;
    logic [31:0] op_b8 = 32'b0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [31:0] result8;
    logic        zero8;
    logic [3:0]  alu_ctrl8;

    always #5 clk = ~clk;

    alu_seq_unit #(.XLEN(32), .SHIFT_STEP(1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct3(funct3), .alt_op(alt_op),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .alu_ctrl(alu_ctrl)
    );

    alu_seq_unit #(.XLEN(32), .SHIFT_STEP(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .aluop(aluop8), .funct3(funct38), .alt_op(alt_op8),
        .op_a(op_a8), .op_b(op_b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .zero(zero8), .alu_ctrl(alu_ctrl8)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: whole-operation result and latency from the ISA rules
    function automatic void model(input logic [2:0] aop, input logic [2:0] f3,
                                  input logic alt, input logic [31:0] a,
                                  input logic [31:0] b, input int stp,
                                  output logic [31:0] r, output logic [3:0] c,
                                  output int lat);
        int sh;
        sh  = int'(b[4:0]);
        c   = 4'd0;
        r   = a + b;
        lat = 1;
        if (aop == 3'b001) begin
            c = 4'd1; r = a - b;
        end else if (aop == 3'b111) begin
            case (f3)
                3'd0: if (alt) begin c = 4'd1; r = a - b; end
                3'd1: begin c = 4'd3; r = a << sh; lat = 1 + (sh + stp - 1) / stp; end
                3'd2: begin c = 4'd8; r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                3'd3: begin c = 4'd9; r = (a < b) ? 32'd1 : 32'd0; end
                3'd4: begin c = 4'd5; r = a ^ b; end
                3'd5: begin
                    c   = alt ? 4'd7 : 4'd6;
                    r   = alt ? 32'($signed(a) >>> sh) : (a >> sh);
                    lat = 1 + (sh + stp - 1) / stp;
                end
                3'd6: begin c = 4'd4; r = a | b; end
                default: begin c = 4'd2; r = a & b; end
            endcase
        end
    endfunction

    typedef struct {
        logic [31:0] res;
        logic [3:0]  ctrl;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    bit   acc_flag = 1'b0;

    function automatic bit exp_valid();
        return q.size() > 0 && cyc >= q[0].due;
    endfunction

    function automatic bit exp_ready();
        return q.size() == 0 || (exp_valid() && out_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            acc_flag = 1'b0;
        end else begin : mdl
            bit   ev;
            bit   er;
            exp_t e;
            int   lat;
            ev = exp_valid();
            er = exp_ready();
            acc_flag = in_valid && er;
            if (ev && out_ready) void'(q.pop_front());
            cyc++;
            if (acc_flag) begin
                model(aluop, funct3, alt_op, op_a, op_b, 1, e.res, e.ctrl, lat);
                e.due = cyc + lat - 1;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid()});
            check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready()});
            if (exp_valid()) begin
                check("result", result, q[0].res);
                check("zero", {31'b0, zero}, {31'b0, q[0].res == 32'b0});
                check("alu_ctrl", {28'b0, alu_ctrl}, {28'b0, q[0].ctrl});
            end
        end
    end

    bit ready_rand = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] aop, input logic [2:0] f3,
                         input logic alt, input logic [31:0] a,
                         input logic [31:0] b);
        aluop = aop; funct3 = f3; alt_op = alt; op_a = a; op_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            sync();
            if (acc_flag) begin
                in_valid = 1'b0;
                // scramble operands: the unit must have captured them
                aluop = 3'($urandom); funct3 = 3'($urandom);
                alt_op = 1'($urandom); op_a = $urandom; op_b = $urandom;
                return;
            end
        end
        n_chk++; n_fail++;
        $display("FAIL issue: request not accepted within 200 cycles");
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (out_valid) return;
        end
        n_chk++; n_fail++;
        $display("FAIL wait_valid: no out_valid within 200 cycles");
    endtask

    task automatic run8(input logic [31:0] a, input logic [4:0] sh);
        logic [31:0] r;
        logic [3:0]  c;
        int          lat;
        int          n;
        model(3'b111, 3'b101, 1'b1, a, {27'b0, sh}, 8, r, c, lat);
        check("s8_in_ready", {31'b0, in_ready8}, 32'd1);
        aluop8 = 3'b111; funct38 = 3'b101; alt_op8 = 1'b1;
        op_a8 = a; op_b8 = {$urandom_range(0, 255), 19'b0, sh};
        in_valid8 = 1'b1;
        sync();
        in_valid8 = 1'b0;
        op_a8 = $urandom;
        op_b8 = $urandom;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (out_valid8) break;
        end
        check("s8_latency", n, lat);
        check("s8_result", result8, r);
        check("s8_zero", {31'b0, zero8}, {31'b0, r == 32'b0});
        check("s8_ctrl", {28'b0, alu_ctrl8}, {28'b0, c});
        sync();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        logic [2:0]  ra;
        logic [2:0]  rf;
        logic        rt;
        logic [31:0] x;
        logic [31:0] y;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd1);
        check("rst_ctrl", {28'b0, alu_ctrl}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        sync();

        issue(3'b111, 3'b000, 1'b1, 32'd5, 32'd7);
        wait_valid(n);
        check("sub_lat", n, 32'd1);
        check("sub_result", result, 32'hFFFF_FFFE);
        check("sub_zero", {31'b0, zero}, 32'd0);
        sync();

        issue(3'b001, 3'b101, 1'b0, 32'h1234, 32'h1234);
        wait_valid(n);
        check("sub0_result", result, 32'd0);
        check("sub0_zero", {31'b0, zero}, 32'd1);
        sync();

        issue(3'b111, 3'b101, 1'b1, 32'h8000_0000, 32'd31);
        wait_valid(n);
        check("sra_lat", n, 32'd32);
        check("sra_result", result, 32'hFFFF_FFFF);
        sync();

        issue(3'b111, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_valid(n);
        check("slt_result", result, 32'd1);
        sync();
        issue(3'b111, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_valid(n);
        check("sltu_result", result, 32'd0);
        sync();
        issue(3'b010, 3'b111, 1'b0, 32'd3, 32'd4);
        wait_valid(n);
        check("undef_result", result, 32'd7);
        check("undef_ctrl", {28'b0, alu_ctrl}, 32'd0);
        sync();

        out_ready = 1'b0;
        issue(3'b111, 3'b111, 1'b0, 32'hF0F0, 32'h0FF0);
        repeat (4) begin
            @(negedge clk);
            check("bp_result", result, 32'h00F0);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        sync();
        aluop = 3'b000; funct3 = 3'b000; alt_op = 1'b0;
        op_a = 32'd10; op_b = 32'd20;
        in_valid = 1'b1; out_ready = 1'b1;
        sync();
        check("b2b_accept", {31'b0, acc_flag}, 32'd1);
        in_valid = 1'b0; op_a = 32'd99;
        @(negedge clk);
        check("b2b_result", result, 32'd30);
        check("b2b_valid", {31'b0, out_valid}, 32'd1);
        sync();

        issue(3'b111, 3'b001, 1'b0, 32'hDEAD_BEEF, 32'h0000_0020);
        wait_valid(n);
        check("sh0_lat", n, 32'd1);
        check("sh0_result", result, 32'hDEAD_BEEF);
        sync();

        issue(3'b111, 3'b001, 1'b0, 32'd1, 32'd20);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rmid_out_valid", {31'b0, out_valid}, 32'd0);
        check("rmid_result", result, 32'd0);
        check("rmid_zero", {31'b0, zero}, 32'd1);
        check("rmid_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        sync();

        ready_rand = 1'b1;
        repeat (300) begin
            ra = ($urandom_range(0, 9) < 7) ? 3'b111 : 3'($urandom);
            rf = 3'($urandom);
            rt = 1'($urandom);
            x  = $urandom;
            y  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 5) == 0) y = x;
            issue(ra, rf, rt, x, y);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) sync();
        end
        ready_rand = 1'b0;
        out_ready = 1'b1;
        repeat (40) sync();

        run8(32'h8000_0000, 5'd31);
        check("s8_sra_lit", result8, 32'hFFFF_FFFF);
        run8(32'h1234_5678, 5'd0);
        run8(32'h8765_4321, 5'd8);
        run8(32'hC000_0001, 5'd9);
        repeat (6) run8($urandom, 5'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
